pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. Each cycle it decides which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) load, hold or flush. It covers three cases: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory accesses. It also keeps saturating stall and flush statistics for debug.

## Interface
- `MEM_TIMEOUT`, default 255: max wait cycles on a data-memory access before abort.
- `CNT_W`, default 16: width of statistics counters.
- `Clock` in 1: pipeline clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `ID_rs` in 5: rs field of the instruction in ID.
- `ID_rt` in 5: rt field of the instruction in ID.
- `ID_UsesRt` in 1: ID instruction reads rt as a source.
- `EX_MemRead` in 1: instruction in EX is a load.
- `EX_rDest` in 5: destination register of the instruction in EX.
- `MEM_PCSrc` in 1: taken branch/jump resolved in MEM.
- `MEM_MemAccess` in 1: load or store present in MEM.
- `DMem_Ready` in 1: data memory completes the access this cycle.
- `DMem_Req` out 1: access request to data memory.
- `PC_Write` out 1: PC register load enable.
- `IFID_Write` out 1: IF/ID load enable.
- `IDEX_Write` out 1: ID/EX load enable.
- `EXMEM_Write` out 1: EX/MEM load enable.
- `IFID_Flush`, `IDEX_Flush`, `EXMEM_Flush` out 1 each: load a bubble (all control bits 0) into that register.
- `MEMWB_Bubble` out 1: force RegWrite=0 and MemToReg=0 into MEM/WB this cycle.
- `Timeout_Err` out 1: sticky, set on memory timeout.
- `StallCycles` out `CNT_W`: saturating count of stalled cycles.
- `FlushEvents` out `CNT_W`: saturating count of branch flushes.

## Operation
- States: RUN, MEM_WAIT.
- **Reset values.** State RUN, wait counter 0, `Timeout_Err`=0, both counters 0. During reset all `*_Write`=1, all flushes=0, `DMem_Req`=0, `MEMWB_Bubble`=0.

**RUN**
- `DMem_Req` = `MEM_MemAccess`.
- **Memory stall.** If `MEM_MemAccess` && !`DMem_Ready`:
  - enter MEM_WAIT;
  - this cycle: `PC_Write`/`IFID_Write`/`IDEX_Write`/`EXMEM_Write`=0 and `MEMWB_Bubble`=1.
- **Taken branch.** Else if `MEM_PCSrc`:
  - `IFID_Flush`, `IDEX_Flush`, `EXMEM_Flush`=1;
  - `PC_Write`=1, so the PC takes the target;
  - `FlushEvents`+1.
- **Load-use hazard.** Else if `EX_MemRead` && `EX_rDest`≠0 && (`EX_rDest`==`ID_rs` || (`ID_UsesRt` && `EX_rDest`==`ID_rt`)):
  - `PC_Write`=0, `IFID_Write`=0;
  - `IDEX_Flush`=1;
  - `StallCycles`+1.
- Otherwise all enables=1 and no flushes.

**MEM_WAIT**
- `DMem_Req`=1.
- Upstream enables=0 and `MEMWB_Bubble`=1 each cycle. `StallCycles`+1 each cycle, including the entry cycle.
- The wait counter increments each cycle.
- **Ready.** On `DMem_Ready`=1:
  - `MEMWB_Bubble`=0 and `EXMEM_Write`=1 that cycle, so the result advances;
  - the branch and load-use rules are evaluated as in RUN for that cycle;
  - next state RUN.
- **Timeout.** When the wait counter reaches `MEM_TIMEOUT` without ready:
  - set `Timeout_Err`;
  - treat the access as completed with a bubble (`MEMWB_Bubble`=1, `EXMEM_Flush`=1);
  - return to RUN.
- The wait counter clears on leaving MEM_WAIT.

**Priority and arithmetic**
- Priority: memory wait > branch flush > load-use.
- A branch flush suppresses the load-use stall in the same cycle.
- Counters saturate at all-ones. No wrap.
- `Timeout_Err` clears only on reset.

## Timing
- Enables and flushes are combinational from inputs and the current state, valid in the same cycle. The pipeline registers act on the next rising edge.
- State, counters and `Timeout_Err` update on the rising edge.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 3 squashed instructions.
- A memory access with ready in the request cycle costs 0 stall cycles. Ready after N wait cycles costs N stall cycles.
- An asynchronous reset mid-MEM_WAIT returns to RUN immediately, drops `DMem_Req` and clears the counters.
- `MEM_PCSrc` and `MEM_MemAccess` both high: the memory access has precedence. The branch is applied in the cycle ready arrives.

## Structure
- Package `pipeline_ctrl_pkg`:
  - state enum (RUN, MEM_WAIT);
  - register-number width (5);
  - the constant for register `$zero`.
- Sub-module `sat_counter` (parameter `W`; ports inc, clear, count), instantiated twice for the statistics.
- The load-use comparator stays inline.

## Test plan
- Load `$t0` in EX; ID reads `$t0` as rs → one cycle with `PC_Write`=0, `IFID_Write`=0, `IDEX_Flush`=1. Next cycle all enables=1. `StallCycles`=1.
- Load to `$zero` in EX; ID reads `$zero` → no stall.
- `MEM_PCSrc`=1 in RUN → all three flushes for 1 cycle, `PC_Write`=1, `FlushEvents`=1. With a simultaneous load-use match → no stall.
- Access with `DMem_Ready` low for 3 cycles, then high → 3 cycles of upstream enables=0 and `MEMWB_Bubble`=1. `DMem_Req` held throughout. `StallCycles`=3, then RUN.
- `MEM_TIMEOUT`=4, ready never asserted → after 4 wait cycles `Timeout_Err`=1, `EXMEM_Flush`=1, RUN. A reset pulse then clears it to 0.
- Reset asserted during MEM_WAIT → `DMem_Req`=0 and state RUN immediately. The counters read 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush debug statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, taken branch
// in MEM, and multi-cycle data-memory accesses with timeout.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_rDest,
    input  logic             MEM_PCSrc,
    input  logic             MEM_MemAccess,
    input  logic             DMem_Ready,
    output logic             DMem_Req,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             MEMWB_Bubble,
    output logic             Timeout_Err,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic load_use;
    logic apply_rules;
    logic stall_inc, flush_inc;
    logic req, pc_we, ifid_we, idex_we, exmem_we;
    logic ifid_fl, idex_fl, exmem_fl, bubble;

    assign load_use = EX_MemRead && (EX_rDest != REG_ZERO) &&
                      ((EX_rDest == ID_rs) || (ID_UsesRt && (EX_rDest == ID_rt)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        req           = 1'b0;
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        idex_we       = 1'b1;
        exmem_we      = 1'b1;
        ifid_fl       = 1'b0;
        idex_fl       = 1'b0;
        exmem_fl      = 1'b0;
        bubble        = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        apply_rules   = 1'b0;

        case (state_q)
            ST_RUN: begin
                req = MEM_MemAccess;
                if (MEM_MemAccess && !DMem_Ready) begin
                    state_d   = ST_MEM_WAIT;
                    pc_we     = 1'b0;
                    ifid_we   = 1'b0;
                    idex_we   = 1'b0;
                    exmem_we  = 1'b0;
                    bubble    = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    apply_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                req        = 1'b1;
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (DMem_Ready) begin
                    state_d     = ST_RUN;
                    wait_cnt_d  = '0;
                    apply_rules = 1'b1;
                end else begin
                    pc_we     = 1'b0;
                    ifid_we   = 1'b0;
                    idex_we   = 1'b0;
                    exmem_we  = 1'b0;
                    bubble    = 1'b1;
                    stall_inc = 1'b1;
                    // Abort: EX/MEM takes a bubble while ID/EX holds, so the EX op replays.
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        timeout_err_d = 1'b1;
                        exmem_we      = 1'b1;
                        exmem_fl      = 1'b1;
                        state_d       = ST_RUN;
                        wait_cnt_d    = '0;
                    end
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (apply_rules) begin
            if (MEM_PCSrc) begin
                ifid_fl   = 1'b1;
                idex_fl   = 1'b1;
                exmem_fl  = 1'b1;
                flush_inc = 1'b1;
            end else if (load_use) begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                idex_fl   = 1'b1;
                stall_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // While reset is held the pipeline free-runs with no requests or bubbles.
    assign DMem_Req     = Reset & req;
    assign PC_Write     = ~Reset | pc_we;
    assign IFID_Write   = ~Reset | ifid_we;
    assign IDEX_Write   = ~Reset | idex_we;
    assign EXMEM_Write  = ~Reset | exmem_we;
    assign IFID_Flush   = Reset & ifid_fl;
    assign IDEX_Flush   = Reset & idex_fl;
    assign EXMEM_Flush  = Reset & exmem_fl;
    assign MEMWB_Bubble = Reset & bubble;
    assign Timeout_Err  = timeout_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clock),
        .rst_n (Reset),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clock),
        .rst_n (Reset),
        .inc   (flush_inc),
        .clear (1'b0),
        .count (FlushEvents)
    );

endmodule
